// File: rtl/gf_mult_pipe.sv
// Pipelined GF(2^M) multiply-accumulate: out_p = (a*b mod G) ^ c, G = x^M + in_g, ROWS array rows per stage.
// Latency M/ROWS cycles from acceptance to out_valid; sustains one operation per cycle.
// Backpressure: global stall, in_ready = ~out_valid | out_ready; a stalled pipe freezes whole, bubbles kept.
module gf_mult_pipe #(
  parameter int M    = 8,
  parameter int ROWS = 1,
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [M-1:0]    in_a,
  input  logic [M-1:0]    in_b,
  input  logic [M-1:0]    in_g,
  input  logic [M-1:0]    in_c,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [M-1:0]    out_p,
  output logic [TAGW-1:0] out_tag,
  output logic            busy
);
  localparam int S = M / ROWS;

  if ((M % ROWS) != 0 || M < 2 || M > 64) begin : g_param_check
    $error("gf_mult_pipe: M must be 2..64 and a multiple of ROWS");
  end

  // Stage registers, index k = 1..S; stage S feeds the output ports directly.
  logic            vld_q [1:S];
  logic [M-1:0]    p_q   [1:S];
  logic [M-1:0]    a_q   [1:S];
  logic [M-1:0]    g_q   [1:S];
  logic [M-1:0]    b_q   [1:S];
  logic [M-1:0]    c_q   [1:S];
  logic [TAGW-1:0] tag_q [1:S];

  // Source of each stage: index 0 is the input ports, index k is stage k.
  logic            src_vld [0:S-1];
  logic [M-1:0]    src_p   [0:S-1];
  logic [M-1:0]    src_a   [0:S-1];
  logic [M-1:0]    src_g   [0:S-1];
  logic [M-1:0]    src_b   [0:S-1];
  logic [M-1:0]    src_c   [0:S-1];
  logic [TAGW-1:0] src_tag [0:S-1];

  // Values each stage captures when the pipe advances.
  logic            nxt_vld [1:S];
  logic [M-1:0]    nxt_p   [1:S];
  logic [M-1:0]    nxt_a   [1:S];
  logic [M-1:0]    nxt_g   [1:S];
  logic [M-1:0]    nxt_b   [1:S];
  logic [M-1:0]    nxt_c   [1:S];
  logic [TAGW-1:0] nxt_tag [1:S];

  logic adv;

  // The whole pipe moves unless a finished result is waiting on the consumer.
  assign adv       = ~vld_q[S] | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_q[S];
  assign out_p     = p_q[S];
  assign out_tag   = tag_q[S];

  // Route the input ports and the first S-1 stages to their successors.
  always_comb begin
    src_vld[0] = in_valid;
    src_p[0]   = '0;
    src_a[0]   = in_a;
    src_g[0]   = in_g;
    src_b[0]   = in_b;
    src_c[0]   = in_c;
    src_tag[0] = in_tag;
    for (int k = 1; k < S; k++) begin
      src_vld[k] = vld_q[k];
      src_p[k]   = p_q[k];
      src_a[k]   = a_q[k];
      src_g[k]   = g_q[k];
      src_b[k]   = b_q[k];
      src_c[k]   = c_q[k];
      src_tag[k] = tag_q[k];
    end
  end

  // Apply ROWS array rows per stage; b is consumed MSB first and shifted left, c is folded in after the last row.
  always_comb begin : rows
    logic [M-1:0] p;
    logic [M-1:0] b;
    p = '0;
    b = '0;
    for (int k = 1; k <= S; k++) begin
      p = src_p[k-1];
      b = src_b[k-1];
      for (int r = 0; r < ROWS; r++) begin
        p = {p[M-2:0], 1'b0} ^ (p[M-1] ? src_g[k-1] : '0) ^ (b[M-1] ? src_a[k-1] : '0);
        b = {b[M-2:0], 1'b0};
      end
      nxt_vld[k] = src_vld[k-1];
      nxt_p[k]   = (k == S) ? (p ^ src_c[k-1]) : p;
      nxt_a[k]   = src_a[k-1];
      nxt_g[k]   = src_g[k-1];
      nxt_b[k]   = b;
      nxt_c[k]   = src_c[k-1];
      nxt_tag[k] = src_tag[k-1];
    end
  end

  // Pipeline registers: cleared by reset, loaded together on adv, otherwise frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= S; k++) begin
        vld_q[k] <= 1'b0;
        p_q[k]   <= '0;
        a_q[k]   <= '0;
        g_q[k]   <= '0;
        b_q[k]   <= '0;
        c_q[k]   <= '0;
        tag_q[k] <= '0;
      end
    end else if (adv) begin
      for (int k = 1; k <= S; k++) begin
        vld_q[k] <= nxt_vld[k];
        p_q[k]   <= nxt_p[k];
        a_q[k]   <= nxt_a[k];
        g_q[k]   <= nxt_g[k];
        b_q[k]   <= nxt_b[k];
        c_q[k]   <= nxt_c[k];
        tag_q[k] <= nxt_tag[k];
      end
    end
  end

  // busy reflects any stage holding a live operation.
  always_comb begin
    busy = 1'b0;
    for (int k = 1; k <= S; k++) begin
      busy = busy | vld_q[k];
    end
  end

endmodule

// File: tb/tb_gf_mult_pipe.sv
// Self-checking bench for gf_mult_pipe: five parameter sets driven one at a time.
// Expected results come from a carry-less multiply plus polynomial long division.
// Results are matched in order against a queue of accepted operations.
module tb_gf_mult_pipe;
  localparam int NI = 5;

  logic clk = 1'b0;
  logic rst_n;

  logic        iv   [NI];
  logic        ordy [NI];
  logic [15:0] ia   [NI];
  logic [15:0] ib   [NI];
  logic [15:0] ig   [NI];
  logic [15:0] ic   [NI];
  logic [3:0]  itag [NI];
  logic        ir   [NI];
  logic        ov   [NI];
  logic        bsy  [NI];
  logic [3:0]  ot   [NI];
  logic [15:0] op   [NI];

  logic [7:0]  p0, p1, p2;
  logic [3:0]  p3;
  logic [15:0] p4;

  assign op[0] = {8'h00, p0};
  assign op[1] = {8'h00, p1};
  assign op[2] = {8'h00, p2};
  assign op[3] = {12'h000, p3};
  assign op[4] = p4;

  always #5 clk = ~clk;

  gf_mult_pipe #(.M(8), .ROWS(1), .TAGW(4)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_a(ia[0][7:0]), .in_b(ib[0][7:0]), .in_g(ig[0][7:0]), .in_c(ic[0][7:0]), .in_tag(itag[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_p(p0), .out_tag(ot[0]), .busy(bsy[0]));

  gf_mult_pipe #(.M(8), .ROWS(2), .TAGW(4)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_a(ia[1][7:0]), .in_b(ib[1][7:0]), .in_g(ig[1][7:0]), .in_c(ic[1][7:0]), .in_tag(itag[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_p(p1), .out_tag(ot[1]), .busy(bsy[1]));

  gf_mult_pipe #(.M(8), .ROWS(8), .TAGW(4)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_a(ia[2][7:0]), .in_b(ib[2][7:0]), .in_g(ig[2][7:0]), .in_c(ic[2][7:0]), .in_tag(itag[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_p(p2), .out_tag(ot[2]), .busy(bsy[2]));

  gf_mult_pipe #(.M(4), .ROWS(1), .TAGW(4)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]),
    .in_a(ia[3][3:0]), .in_b(ib[3][3:0]), .in_g(ig[3][3:0]), .in_c(ic[3][3:0]), .in_tag(itag[3]),
    .out_valid(ov[3]), .out_ready(ordy[3]), .out_p(p3), .out_tag(ot[3]), .busy(bsy[3]));

  gf_mult_pipe #(.M(16), .ROWS(4), .TAGW(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[4]), .in_ready(ir[4]),
    .in_a(ia[4]), .in_b(ib[4]), .in_g(ig[4]), .in_c(ic[4]), .in_tag(itag[4]),
    .out_valid(ov[4]), .out_ready(ordy[4]), .out_p(p4), .out_tag(ot[4]), .busy(bsy[4]));

  // Per-instance field degree, expected latency M/ROWS and field polynomial.
  function automatic int m_of(input int i);
    case (i)
      3:       return 4;
      4:       return 16;
      default: return 8;
    endcase
  endfunction

  function automatic int l_of(input int i);
    case (i)
      0:       return 8;
      2:       return 1;
      default: return 4;
    endcase
  endfunction

  function automatic logic [15:0] g_of(input int i);
    case (i)
      3:       return 16'h0003;
      4:       return 16'h100B;
      default: return 16'h001B;
    endcase
  endfunction

  // Reference: full 2M-bit carry-less product, then reduce by x^m + g from the top down.
  function automatic logic [15:0] gf_ref(input logic [15:0] a, input logic [15:0] b,
                                         input logic [15:0] g, input logic [15:0] c, input int m);
    logic [31:0] prod;
    logic [31:0] poly;
    prod = '0;
    for (int j = 0; j < m; j++)
      if (b[j]) prod = prod ^ (32'(a) << j);
    poly = (32'h1 << m) | 32'(g);
    for (int j = 2 * m - 2; j >= m; j--)
      if (prod[j]) prod = prod ^ (poly << (j - m));
    return prod[15:0] ^ c;
  endfunction

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_sent = 0;

  logic [15:0] exp_p [$];
  logic [3:0]  exp_t [$];
  int          exp_c [$];

  bit          pend;
  bit          use_forced;
  bit          chk_lat;
  logic [15:0] pa, pb, pc, pexp;
  logic [15:0] fa, fb, fc, fexp;
  logic [3:0]  tag_ctr;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  // One clock cycle on instance i: drive at the falling edge, check the result handshake,
  // and record an acceptance that the next rising edge will perform.
  task automatic step(input int i, input bit offer, input bit rdy);
    logic [15:0] msk;
    msk = 16'((32'h1 << m_of(i)) - 1);
    @(negedge clk);
    cyc++;
    if (offer && !pend) begin
      if (use_forced) begin
        pa = fa; pb = fb; pc = fc; pexp = fexp;
        use_forced = 1'b0;
      end else begin
        pa = 16'($urandom) & msk;
        pc = 16'($urandom) & msk;
        case (n_sent % 4)
          0:       pb = 16'h0001;
          1:       pb = 16'h0000;
          default: pb = 16'($urandom) & msk;
        endcase
        pexp = gf_ref(pa, pb, g_of(i), pc, m_of(i));
      end
      pend = 1'b1;
    end
    iv[i]   = offer;
    ia[i]   = pa;
    ib[i]   = pb;
    ic[i]   = pc;
    ig[i]   = g_of(i);
    itag[i] = tag_ctr;
    ordy[i] = rdy;
    #1;
    if (ov[i] && rdy) begin
      chk("result_expected", 32'(exp_p.size() != 0), 32'd1);
      if (exp_p.size() != 0) begin
        chk("out_p", 32'(op[i]), 32'(exp_p[0]));
        chk("out_tag", 32'(ot[i]), 32'(exp_t[0]));
        if (chk_lat) chk("latency", 32'(cyc - exp_c[0]), 32'(l_of(i)));
        void'(exp_p.pop_front());
        void'(exp_t.pop_front());
        void'(exp_c.pop_front());
      end
    end
    if (offer && ir[i]) begin
      exp_p.push_back(pexp);
      exp_t.push_back(tag_ctr);
      exp_c.push_back(cyc);
      pend = 1'b0;
      tag_ctr = tag_ctr + 4'd1;
      n_sent++;
    end
  endtask

  task automatic drain(input int i, input bit rnd);
    int budget;
    budget = 400;
    while ((exp_p.size() != 0 || pend) && budget > 0) begin
      step(i, pend, rnd ? 1'($urandom) : 1'b1);
      budget--;
    end
    iv[i] = 1'b0;
    ordy[i] = 1'b1;
    chk("drain_queue_empty", 32'(exp_p.size()), 32'd0);
    chk("drain_nothing_pending", 32'(pend), 32'd0);
  endtask

  task automatic stream(input int i, input int n, input bit rnd);
    int start;
    int budget;
    start = n_sent;
    budget = 4 * n + 100;
    chk_lat = !rnd;
    while ((n_sent - start) < n && budget > 0) begin
      step(i, 1'b1, rnd ? 1'($urandom) : 1'b1);
      budget--;
    end
    chk("stream_accepted", 32'(n_sent - start), 32'(n));
    drain(i, rnd);
    chk_lat = 1'b1;
  endtask

  task automatic directed(input int i, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [15:0] e);
    fa = a; fb = b; fc = c; fexp = e;
    use_forced = 1'b1;
    chk_lat = 1'b1;
    step(i, 1'b1, 1'b1);
    drain(i, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NI; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b1;
      ia[i] = '0; ib[i] = '0; ig[i] = '0; ic[i] = '0; itag[i] = '0;
    end
    pend = 1'b0; use_forced = 1'b0; chk_lat = 1'b1; tag_ctr = '0;
    pa = '0; pb = '0; pc = '0; pexp = '0;
    fa = '0; fb = '0; fc = '0; fexp = '0;
    rst_n = 1'b0;

    // Reset state on every instance.
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("rst_out_valid", 32'(ov[i]), 32'd0);
      chk("rst_busy", 32'(bsy[i]), 32'd0);
      chk("rst_out_p", 32'(op[i]), 32'd0);
      chk("rst_out_tag", 32'(ot[i]), 32'd0);
      chk("rst_in_ready", 32'(ir[i]), 32'd1);
    end
    rst_n = 1'b1;

    // Known AES-field products, and x^3+1 times x^3+x+1 reduced by x^4+x+1 gives x^3+x^2.
    directed(0, 16'h57, 16'h83, 16'h00, 16'hC1);
    directed(0, 16'h53, 16'hCA, 16'h00, 16'h01);
    directed(0, 16'h57, 16'h13, 16'hFF, 16'h01);
    directed(3, 16'h9, 16'hB, 16'h0, 16'hC);

    // Back-to-back streaming with identity operands mixed in.
    stream(0, 256, 1'b0);

    // Fill the pipe against a stalled consumer, then hold for 20 cycles.
    chk_lat = 1'b0;
    repeat (l_of(0) + 2) step(0, 1'b1, 1'b0);
    repeat (20) begin
      step(0, 1'b1, 1'b0);
      chk("hold_in_ready", 32'(ir[0]), 32'd0);
      chk("hold_busy", 32'(bsy[0]), 32'd1);
      chk("hold_out_valid", 32'(ov[0]), 32'd1);
      chk("hold_out_p", 32'(op[0]), 32'(exp_p[0]));
      chk("hold_out_tag", 32'(ot[0]), 32'(exp_t[0]));
    end
    chk("hold_inflight", 32'(exp_p.size()), 32'(l_of(0)));
    repeat (60) step(0, 1'($urandom), 1'($urandom));
    drain(0, 1'b1);

    // Other parameter sets: exact latency with a free consumer, then random backpressure.
    for (int i = 1; i < NI; i++) begin
      stream(i, 40, 1'b0);
      stream(i, 40, 1'b1);
    end

    // Reset with five operations in flight and the consumer stalled.
    chk_lat = 1'b0;
    repeat (5) step(0, 1'b1, 1'b0);
    chk("inflight_before_reset", 32'(exp_p.size()), 32'd5);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(ov[0]), 32'd0);
    chk("midrst_busy", 32'(bsy[0]), 32'd0);
    chk("midrst_out_p", 32'(op[0]), 32'd0);
    chk("midrst_in_ready", 32'(ir[0]), 32'd1);
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    exp_p.delete();
    exp_t.delete();
    exp_c.delete();
    pend = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (12) step(0, 1'b0, 1'b1);
    chk("post_rst_busy", 32'(bsy[0]), 32'd0);
    directed(0, 16'h57, 16'h83, 16'h00, 16'hC1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
